// File: rtl/regfile_scoreboard.sv
// Register file with same-cycle write bypass and a per-register pending
// (scoreboard) bit for multi-cycle producers, plus a registered pending count.
module regfile_scoreboard #(
    parameter int bits            = 32,
    parameter int no_of_registers = 32,
    parameter int read_ports      = 2,
    parameter int addr_width_DMEM = 10,
    parameter int sp_index        = 2,
    localparam int AW             = $clog2(no_of_registers),
    localparam int CW             = $clog2(no_of_registers + 1)
) (
    input  logic                       clk,
    input  logic                       async_reset,
    input  logic [read_ports*AW-1:0]   rd_addr,
    output logic [read_ports*bits-1:0] rd_data,
    output logic [read_ports-1:0]      rd_busy,
    input  logic                       wr_en,
    input  logic [AW-1:0]              wr_addr,
    input  logic [bits-1:0]            wr_data,
    input  logic                       issue_en,
    input  logic [AW-1:0]              issue_addr,
    output logic                       issue_waw,
    output logic [CW-1:0]              busy_count
);

    localparam logic [bits-1:0] SP_RESET = {{(bits-1){1'b0}}, 1'b1} << addr_width_DMEM;

    typedef logic [no_of_registers-1:0][bits-1:0] reg_array_t;

    function automatic reg_array_t reset_regs();
        reg_array_t r;
        r           = '0;
        r[sp_index] = SP_RESET;
        return r;
    endfunction

    // Declaration initialisers make the power-up contents match the reset contents.
    reg_array_t                 regs_q = reset_regs();
    reg_array_t                 regs_d;
    logic [no_of_registers-1:0] busy_q = '0;
    logic [no_of_registers-1:0] busy_d;
    logic [CW-1:0]              busy_count_q = '0;
    logic [CW-1:0]              busy_count_d;

    always_comb begin
        regs_d = regs_q;
        if (wr_en && wr_addr != '0) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    // Clear before set so an issue and a writeback to the same register keep it pending.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (issue_en && issue_addr != '0) begin
            busy_d[issue_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        busy_count_d = '0;
        for (int i = 0; i < no_of_registers; i++) begin
            busy_count_d = busy_count_d + CW'(busy_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (async_reset) begin
            regs_q       <= reset_regs();
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            regs_q       <= regs_d;
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int p = 0; p < read_ports; p++) begin
            if (rd_addr[p*AW +: AW] != '0) begin
                if (wr_en && wr_addr == rd_addr[p*AW +: AW]) begin
                    rd_data[p*bits +: bits] = wr_data;
                end else begin
                    rd_data[p*bits +: bits] = regs_q[rd_addr[p*AW +: AW]];
                end
                rd_busy[p] = busy_q[rd_addr[p*AW +: AW]] &&
                             !(wr_en && wr_addr == rd_addr[p*AW +: AW]);
            end
        end
    end

    assign issue_waw  = issue_en && issue_addr != '0 && busy_q[issue_addr] &&
                        !(wr_en && wr_addr == issue_addr);
    assign busy_count = busy_count_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed-vector bench for regfile_scoreboard at default parameters
// (32 x 32-bit, two read ports, stack pointer x2 resets to 0x400).
module tb_regfile_scoreboard;

    localparam int AW = 5;
    localparam int CW = 6;

    logic            clk;
    logic            async_reset;
    logic [2*AW-1:0] rd_addr;
    logic [63:0]     rd_data;
    logic [1:0]      rd_busy;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [31:0]     wr_data;
    logic            issue_en;
    logic [AW-1:0]   issue_addr;
    logic            issue_waw;
    logic [CW-1:0]   busy_count;

    int compared   = 0;
    int mismatched = 0;

    regfile_scoreboard dut (
        .clk        (clk),
        .async_reset(async_reset),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .issue_waw  (issue_waw),
        .busy_count (busy_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One record per clock cycle; expected outputs are sampled before that cycle's edge.
    typedef struct {
        logic          rst;
        logic          we;
        logic [AW-1:0] wa;
        logic [31:0]   wd;
        logic          ie;
        logic [AW-1:0] ia;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic [31:0]   exp_d0;
        logic [31:0]   exp_d1;
        logic [1:0]    exp_busy;
        logic          exp_waw;
        logic [CW-1:0] exp_cnt;
    } vec_t;

    function automatic vec_t mk(logic rst, logic we, logic [AW-1:0] wa, logic [31:0] wd,
                                logic ie, logic [AW-1:0] ia, logic [AW-1:0] ra0,
                                logic [AW-1:0] ra1, logic [31:0] d0, logic [31:0] d1,
                                logic [1:0] bz, logic waw, logic [CW-1:0] cnt);
        vec_t v;
        v.rst = rst; v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.ia = ia;
        v.ra0 = ra0; v.ra1 = ra1; v.exp_d0 = d0; v.exp_d1 = d1;
        v.exp_busy = bz; v.exp_waw = waw; v.exp_cnt = cnt;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        async_reset = v.rst;
        wr_en       = v.we;
        wr_addr     = v.wa;
        wr_data     = v.wd;
        issue_en    = v.ie;
        issue_addr  = v.ia;
        rd_addr     = {v.ra1, v.ra0};
    endtask

    task automatic compare_value(input string name, input string tag,
                                 input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s %s: got 0x%0h, expected 0x%0h", tag, name, got, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input vec_t v);
        compare_value("rd_data0",   tag, rd_data[31:0],  v.exp_d0);
        compare_value("rd_data1",   tag, rd_data[63:32], v.exp_d1);
        compare_value("rd_busy",    tag, 32'(rd_busy),   32'(v.exp_busy));
        compare_value("issue_waw",  tag, 32'(issue_waw), 32'(v.exp_waw));
        compare_value("busy_count", tag, 32'(busy_count), 32'(v.exp_cnt));
    endtask

    task automatic run_cycle(input string tag, input vec_t v);
        applyStimulus(v);
        #2;
        checkOutput(tag, v);
        @(negedge clk);
    endtask

    vec_t table_v[16];

    initial begin
        //                 rst we wa  wd            ie ia  ra0 ra1 d0            d1            bz     waw cnt
        table_v[0]  = mk(0, 0, 0,  32'h0,        0, 0,  2,  5,  32'h400,      32'h0,        2'b00, 0, 0);
        table_v[1]  = mk(0, 1, 0,  32'hDEADBEEF, 0, 0,  0,  0,  32'h0,        32'h0,        2'b00, 0, 0);
        table_v[2]  = mk(0, 0, 0,  32'h0,        0, 0,  0,  2,  32'h0,        32'h400,      2'b00, 0, 0);
        table_v[3]  = mk(0, 1, 7,  32'h12345678, 0, 0,  7,  7,  32'h12345678, 32'h12345678, 2'b00, 0, 0);
        table_v[4]  = mk(0, 0, 0,  32'h0,        0, 0,  7,  3,  32'h12345678, 32'h0,        2'b00, 0, 0);
        table_v[5]  = mk(0, 0, 0,  32'h0,        1, 9,  9,  0,  32'h0,        32'h0,        2'b00, 0, 0);
        table_v[6]  = mk(0, 0, 0,  32'h0,        0, 0,  9,  9,  32'h0,        32'h0,        2'b11, 0, 1);
        table_v[7]  = mk(0, 1, 9,  32'hA5,       0, 0,  9,  7,  32'hA5,       32'h12345678, 2'b00, 0, 1);
        table_v[8]  = mk(0, 0, 0,  32'h0,        0, 0,  9,  9,  32'hA5,       32'hA5,       2'b00, 0, 0);
        table_v[9]  = mk(0, 0, 0,  32'h0,        1, 4,  4,  0,  32'h0,        32'h0,        2'b00, 0, 0);
        table_v[10] = mk(0, 1, 4,  32'h44,       1, 4,  4,  4,  32'h44,       32'h44,       2'b00, 0, 1);
        table_v[11] = mk(0, 0, 0,  32'h0,        0, 0,  4,  4,  32'h44,       32'h44,       2'b11, 0, 1);
        table_v[12] = mk(0, 0, 0,  32'h0,        1, 4,  4,  1,  32'h44,       32'h0,        2'b01, 1, 1);
        table_v[13] = mk(0, 0, 0,  32'h0,        0, 0,  4,  0,  32'h44,       32'h0,        2'b01, 0, 1);
        table_v[14] = mk(0, 1, 12, 32'hC,        0, 0,  12, 4,  32'hC,        32'h44,       2'b10, 0, 1);
        table_v[15] = mk(0, 0, 0,  32'h0,        0, 0,  12, 2,  32'hC,        32'h400,      2'b00, 0, 1);

        applyStimulus(mk(1, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0, 2'b00, 0, 0));
        repeat (2) @(posedge clk);
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            run_cycle($sformatf("vec%0d", i), table_v[i]);
        end

        // Reservations in flight are dropped by a reset that also carries a write and an issue.
        run_cycle("rst_seq0", mk(0, 0, 0, 32'h0,  1, 3, 3, 4, 32'h0,  32'h44,  2'b10, 0, 1));
        run_cycle("rst_seq1", mk(0, 0, 0, 32'h0,  1, 5, 3, 5, 32'h0,  32'h0,   2'b01, 0, 2));
        run_cycle("rst_seq2", mk(0, 0, 0, 32'h0,  1, 6, 5, 6, 32'h0,  32'h0,   2'b01, 0, 3));
        run_cycle("rst_seq3", mk(1, 1, 5, 32'h55, 1, 7, 5, 6, 32'h55, 32'h0,   2'b10, 0, 4));
        run_cycle("rst_seq4", mk(0, 0, 0, 32'h0,  0, 0, 5, 2, 32'h0,  32'h400, 2'b00, 0, 0));
        run_cycle("rst_seq5", mk(0, 0, 0, 32'h0,  0, 0, 7, 4, 32'h0,  32'h0,   2'b00, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter bits, default 32, data width of each register.
REQ-002 Parameter no_of_registers, default 32, register count (power of two, >=4); AW = $clog2(no_of_registers).
REQ-003 Parameter read_ports, default 2, number of independent read ports (1..4).
REQ-004 Parameter addr_width_DMEM, default 10, sets stack-pointer reset value 2**addr_width_DMEM.
REQ-005 Parameter sp_index, default 2, register index holding the stack pointer.
REQ-006 clk  input  1  single clock, all state updates on rising edge.
REQ-007 async_reset  input  1  reset, synchronous, active-high (sampled on posedge clk only).
REQ-008 rd_addr  input  read_ports*AW  packed read addresses, port i at bits [i*AW +: AW].
REQ-009 rd_data  output  read_ports*bits  packed read data, port i at [i*bits +: bits].
REQ-010 rd_busy  output  read_ports  port i source has an outstanding, unresolved write.
REQ-011 wr_en  input  1  writeback strobe.
REQ-012 wr_addr  input  AW  writeback destination.
REQ-013 wr_data  input  bits  writeback value.
REQ-014 issue_en  input  1  marks issue_addr as pending (multi-cycle producer issued).
REQ-015 issue_addr  input  AW  destination being reserved.
REQ-016 issue_waw  output  1  issue_en targets a register already pending and not cleared this cycle.
REQ-017 busy_count  output  $clog2(no_of_registers+1)  number of registers currently pending.

Function
REQ-018 Write: on posedge, if wr_en and wr_addr != 0 and not reset, reg[wr_addr] <= wr_data; wr_addr == 0 is discarded.
REQ-019 Register 0 SHALL read 0 on every port and SHALL never be marked pending.
REQ-020 Read: rd_data port i combinational, zero latency, from reg[rd_addr_i].
REQ-021 Bypass: if wr_en and wr_addr == rd_addr_i != 0, rd_data port i = wr_data in the same cycle.
REQ-022 Pending bit per register: issue_en sets busy[issue_addr] (issue_addr != 0); wr_en clears busy[wr_addr].
REQ-023 Simultaneous set and clear of same address in one cycle: set wins, busy stays 1 next cycle.
REQ-024 rd_busy_i = busy[rd_addr_i] & ~(wr_en & wr_addr == rd_addr_i); 0 when rd_addr_i == 0.
REQ-025 issue_waw = issue_en & issue_addr != 0 & busy[issue_addr] & ~(wr_en & wr_addr == issue_addr); purely combinational; issue still recorded (busy remains 1).
REQ-026 wr_en to a non-pending register SHALL update data and leave busy at 0 (no error).
REQ-027 busy_count SHALL be registered, equal to popcount of busy after each edge; net change per cycle in {-1,0,+1}; never exceeds no_of_registers-1.
REQ-028 All read ports independent; identical addresses on several ports return identical data/busy.

Reset
REQ-029 On posedge with async_reset = 1: all registers <= 0 except reg[sp_index] <= 2**addr_width_DMEM; all busy <= 0; busy_count <= 0.
REQ-030 Power-up initial values SHALL equal reset values.
REQ-031 Reset SHALL dominate wr_en and issue_en in the same cycle; pending reservations mid-operation are dropped.
REQ-032 Combinational outputs during reset cycle reflect current state plus bypass; post-reset state per REQ-029.

Verification
REQ-033 Reset, read port0 addr 2, port1 addr 5 -> rd_data 0x400 and 0x0 (bits=32, addr_width_DMEM=10), rd_busy 0, busy_count 0.
REQ-034 wr_en, wr_addr 0, wr_data 0xDEADBEEF; next cycle read addr 0 -> 0x0; same-cycle read addr 0 -> 0x0 (no bypass to x0).
REQ-035 wr_en addr 7 data 0x12345678 while port0 reads 7 -> same cycle rd_data 0x12345678; next cycle unchanged from array.
REQ-036 issue addr 9; next cycle read 9 -> rd_busy 1, busy_count 1; wr_en addr 9 data 0xA5 -> that cycle rd_busy 0, rd_data 0xA5; after edge busy_count 0.
REQ-037 busy[4]=1, same cycle issue_en addr 4 and wr_en addr 4 -> issue_waw 0, busy[4] stays 1, busy_count unchanged; issue addr 4 without wr -> issue_waw 1.
REQ-038 issue addrs 3,5,6 on successive cycles, then async_reset with wr_en addr 5 -> after edge busy_count 0, reg5 = 0, reg2 = 0x400.
